// File: rtl/vu_vxu_bank_seq_pkg.sv
// Shared widths, bank-count limits and FSM encodings for the vector-unit bank sequencer.
package vu_vxu_bank_seq_pkg;

    localparam int SZ_BPTR  = 3;
    localparam int SZ_BPTR1 = 4;
    localparam int SZ_BPTR2 = 5;
    localparam int SZ_BCNT  = 4;

    localparam logic [SZ_BCNT-1:0] BCNT_MIN = 4'd3;
    localparam logic [SZ_BCNT-1:0] BCNT_MAX = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    function automatic logic bcnt_legal(input logic [SZ_BCNT-1:0] b);
        return (b >= BCNT_MIN) && (b <= BCNT_MAX);
    endfunction

endpackage

// File: rtl/vu_vxu_bptr_mod.sv
// Combinational bank-pointer wrap: nptr = (ptr + incr) mod bcnt.
// The sum stays below 8*bcnt for every legal bcnt, so three restoring steps suffice.
module vu_vxu_bptr_mod
    import vu_vxu_bank_seq_pkg::*;
(
    input  logic [SZ_BPTR-1:0]  ptr,
    input  logic [SZ_BPTR1-1:0] incr,
    input  logic [SZ_BCNT-1:0]  bcnt,
    output logic [SZ_BPTR-1:0]  nptr
);

    localparam int RW = SZ_BPTR2 + 1;

    logic [RW-1:0] r;

    always_comb begin
        r = RW'(ptr) + RW'(incr);
        if (r >= {bcnt, 2'b00}) r = r - {bcnt, 2'b00};
        if (r >= RW'({bcnt, 1'b0})) r = r - RW'({bcnt, 1'b0});
        if (r >= RW'(bcnt)) r = r - RW'(bcnt);
    end

    assign nptr = SZ_BPTR'(r);

endmodule

// File: rtl/vu_vxu_bank_seq.sv
// Bank sequencer: 2-entry issue buffer feeding a walker that emits one read/write-back
// bank pair per cycle, wrapping modulo the configured active bank count.
//
// state | meaning
// IDLE  | no op running; loads buffer head when not stalled
// RUN   | output registers hold the current slice; advance on each unstalled cycle
module vu_vxu_bank_seq
    import vu_vxu_bank_seq_pkg::*;
#(
    parameter int VLEN_W = 11,
    parameter int TAG_W  = 4,
    parameter int QDEPTH = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_val,
    input  logic [SZ_BCNT-1:0]  cfg_bcnt,
    output logic                cfg_err,
    input  logic                iss_val,
    output logic                iss_rdy,
    input  logic [SZ_BPTR-1:0]  iss_bptr,
    input  logic [VLEN_W-1:0]   iss_vlen,
    input  logic [SZ_BPTR-1:0]  iss_lat,
    input  logic [TAG_W-1:0]    iss_tag,
    input  logic                stall,
    output logic                seq_val,
    output logic [SZ_BPTR-1:0]  seq_bptr,
    output logic [SZ_BPTR-1:0]  seq_wptr,
    output logic                seq_last,
    output logic [TAG_W-1:0]    seq_tag,
    output logic                busy
);

    logic [SZ_BCNT-1:0] bcnt_q;
    logic               cfg_err_q;

    logic [SZ_BPTR-1:0] q_bptr [QDEPTH];
    logic [VLEN_W-1:0]  q_vlen [QDEPTH];
    logic [SZ_BPTR-1:0] q_lat  [QDEPTH];
    logic [TAG_W-1:0]   q_tag  [QDEPTH];
    logic               q_wr, q_rd;
    logic [1:0]         q_cnt, q_cnt_nxt;
    logic               rdy_q;

    seq_state_e         state_q;
    logic               val_q, last_q;
    logic [SZ_BPTR-1:0] bptr_q, wptr_q, lat_q;
    logic [VLEN_W-1:0]  cnt_q;
    logic [TAG_W-1:0]   tag_q;

    logic               head_vld, push, pop, load_run, busy_w;
    logic [SZ_BPTR-1:0] head_bptr, head_lat;
    logic [VLEN_W-1:0]  head_vlen;
    logic [TAG_W-1:0]   head_tag;
    logic [SZ_BPTR-1:0] start_bptr, adv_bptr, next_bptr, next_lat, next_wptr;

    assign head_vld  = (q_cnt != 2'd0);
    assign head_bptr = q_bptr[q_rd];
    assign head_vlen = q_vlen[q_rd];
    assign head_lat  = q_lat[q_rd];
    assign head_tag  = q_tag[q_rd];

    assign push     = iss_val & rdy_q;
    // Head is taken when idle, or on the final slice so back-to-back ops have no bubble.
    assign pop      = head_vld & ~stall & ((state_q == ST_IDLE) | last_q);
    assign load_run = pop & (head_vlen != '0);
    assign busy_w   = (state_q == ST_RUN) | head_vld;

    assign q_cnt_nxt = q_cnt + 2'(push) - 2'(pop);

    vu_vxu_bptr_mod u_norm (
        .ptr  (head_bptr),
        .incr ('0),
        .bcnt (bcnt_q),
        .nptr (start_bptr)
    );

    vu_vxu_bptr_mod u_adv (
        .ptr  (bptr_q),
        .incr (SZ_BPTR1'(1)),
        .bcnt (bcnt_q),
        .nptr (adv_bptr)
    );

    assign next_bptr = load_run ? start_bptr : adv_bptr;
    assign next_lat  = load_run ? head_lat : lat_q;

    vu_vxu_bptr_mod u_wb (
        .ptr  (next_bptr),
        .incr ({1'b0, next_lat}),
        .bcnt (bcnt_q),
        .nptr (next_wptr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_wr  <= 1'b0;
            q_rd  <= 1'b0;
            q_cnt <= 2'd0;
            rdy_q <= 1'b1;
        end else begin
            if (push) q_wr <= ~q_wr;
            if (pop)  q_rd <= ~q_rd;
            q_cnt <= q_cnt_nxt;
            rdy_q <= (q_cnt_nxt != 2'(QDEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_bptr[q_wr] <= iss_bptr;
            q_vlen[q_wr] <= iss_vlen;
            q_lat[q_wr]  <= iss_lat;
            q_tag[q_wr]  <= iss_tag;
        end
    end

    // Bank count may only change with nothing in flight, so live pointers never exceed it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt_q    <= BCNT_MAX;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            if (cfg_val) begin
                if (!busy_w && bcnt_legal(cfg_bcnt)) bcnt_q <= cfg_bcnt;
                else cfg_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            val_q   <= 1'b0;
            last_q  <= 1'b0;
            bptr_q  <= '0;
            wptr_q  <= '0;
            lat_q   <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else if (load_run) begin
            state_q <= ST_RUN;
            val_q   <= 1'b1;
            bptr_q  <= next_bptr;
            wptr_q  <= next_wptr;
            lat_q   <= head_lat;
            cnt_q   <= head_vlen;
            last_q  <= (head_vlen == VLEN_W'(1));
            tag_q   <= head_tag;
        end else if (state_q == ST_RUN && !stall) begin
            if (last_q) begin
                state_q <= ST_IDLE;
                val_q   <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                bptr_q <= next_bptr;
                wptr_q <= next_wptr;
                cnt_q  <= cnt_q - VLEN_W'(1);
                last_q <= (cnt_q == VLEN_W'(2));
            end
        end
    end

    assign seq_val  = val_q & ~stall;
    assign seq_last = last_q & ~stall;
    assign seq_bptr = bptr_q;
    assign seq_wptr = wptr_q;
    assign seq_tag  = tag_q;
    assign iss_rdy  = rdy_q;
    assign cfg_err  = cfg_err_q;
    assign busy     = busy_w;

endmodule

// File: tb/tb_vu_vxu_bank_seq.sv
// Directed bench for the bank sequencer: per-cycle vector table plus hand-written
// sequences for back-to-back ops, stall, async reset and zero-length ops.
module tb_vu_vxu_bank_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_val;
    logic [3:0]  cfg_bcnt;
    logic        cfg_err;
    logic        iss_val;
    logic        iss_rdy;
    logic [2:0]  iss_bptr;
    logic [10:0] iss_vlen;
    logic [2:0]  iss_lat;
    logic [3:0]  iss_tag;
    logic        stall;
    logic        seq_val;
    logic [2:0]  seq_bptr;
    logic [2:0]  seq_wptr;
    logic        seq_last;
    logic [3:0]  seq_tag;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    vu_vxu_bank_seq #(.VLEN_W(11), .TAG_W(4), .QDEPTH(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cfg_val  (cfg_val),
        .cfg_bcnt (cfg_bcnt),
        .cfg_err  (cfg_err),
        .iss_val  (iss_val),
        .iss_rdy  (iss_rdy),
        .iss_bptr (iss_bptr),
        .iss_vlen (iss_vlen),
        .iss_lat  (iss_lat),
        .iss_tag  (iss_tag),
        .stall    (stall),
        .seq_val  (seq_val),
        .seq_bptr (seq_bptr),
        .seq_wptr (seq_wptr),
        .seq_last (seq_last),
        .seq_tag  (seq_tag),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [3:0]  cb;
        logic        iv;
        logic [2:0]  ib;
        logic [10:0] il;
        logic [2:0]  ia;
        logic [3:0]  it;
        logic        st;
        logic        ev;
        logic [2:0]  eb;
        logic [2:0]  ew;
        logic        el;
        logic [3:0]  et;
        logic        er;
        logic        ey;
        logic        ee;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(input logic cv, input logic [3:0] cb, input logic iv,
                                input logic [2:0] ib, input logic [10:0] il, input logic [2:0] ia,
                                input logic [3:0] it, input logic st,
                                input logic ev, input logic [2:0] eb, input logic [2:0] ew,
                                input logic el, input logic [3:0] et,
                                input logic er, input logic ey, input logic ee);
        vec_t v;
        v.cv = cv; v.cb = cb; v.iv = iv; v.ib = ib; v.il = il; v.ia = ia; v.it = it; v.st = st;
        v.ev = ev; v.eb = eb; v.ew = ew; v.el = el; v.et = et; v.er = er; v.ey = ey; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string nm, input logic ev, input logic [2:0] eb, input logic [2:0] ew,
                         input logic el, input logic [3:0] et, input logic er, input logic ey,
                         input logic ee);
        logic [14:0] got, exp;
        got = {seq_val, seq_bptr, seq_wptr, seq_last, seq_tag, iss_rdy, busy, cfg_err};
        exp = {ev, eb, ew, el, et, er, ey, ee};
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got val=%b bptr=%0d wptr=%0d last=%b tag=%0d rdy=%b busy=%b err=%b, want val=%b bptr=%0d wptr=%0d last=%b tag=%0d rdy=%b busy=%b err=%b",
                     nm, seq_val, seq_bptr, seq_wptr, seq_last, seq_tag, iss_rdy, busy, cfg_err,
                     ev, eb, ew, el, et, er, ey, ee);
        end
    endtask

    task automatic step(input string nm,
                        input logic cv, input logic [3:0] cb, input logic iv, input logic [2:0] ib,
                        input logic [10:0] il, input logic [2:0] ia, input logic [3:0] it,
                        input logic st,
                        input logic ev, input logic [2:0] eb, input logic [2:0] ew, input logic el,
                        input logic [3:0] et, input logic er, input logic ey, input logic ee);
        @(negedge clk);
        cfg_val = cv; cfg_bcnt = cb; iss_val = iv; iss_bptr = ib;
        iss_vlen = il; iss_lat = ia; iss_tag = it; stall = st;
        #1;
        check(nm, ev, eb, ew, el, et, er, ey, ee);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // bcnt=5 walk, bcnt=8 write-back offsets, illegal/busy/legal cfg writes
        tbl[0]  = mk(1,5,0,0,0,0,0,0, 0,0,0,0,0,1,0,0);
        tbl[1]  = mk(0,0,1,3,7,0,1,0, 0,0,0,0,0,1,0,0);
        tbl[2]  = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,1,1,0);
        tbl[3]  = mk(0,0,0,0,0,0,0,0, 1,3,3,0,1,1,1,0);
        tbl[4]  = mk(0,0,0,0,0,0,0,0, 1,4,4,0,1,1,1,0);
        tbl[5]  = mk(0,0,0,0,0,0,0,0, 1,0,0,0,1,1,1,0);
        tbl[6]  = mk(0,0,0,0,0,0,0,0, 1,1,1,0,1,1,1,0);
        tbl[7]  = mk(0,0,0,0,0,0,0,0, 1,2,2,0,1,1,1,0);
        tbl[8]  = mk(0,0,0,0,0,0,0,0, 1,3,3,0,1,1,1,0);
        tbl[9]  = mk(0,0,0,0,0,0,0,0, 1,4,4,1,1,1,1,0);
        tbl[10] = mk(1,8,0,0,0,0,0,0, 0,4,4,0,1,1,0,0);
        tbl[11] = mk(0,0,1,6,3,5,2,0, 0,4,4,0,1,1,0,0);
        tbl[12] = mk(0,0,0,0,0,0,0,0, 0,4,4,0,1,1,1,0);
        tbl[13] = mk(0,0,0,0,0,0,0,0, 1,6,3,0,2,1,1,0);
        tbl[14] = mk(0,0,0,0,0,0,0,0, 1,7,4,0,2,1,1,0);
        tbl[15] = mk(0,0,0,0,0,0,0,0, 1,0,5,1,2,1,1,0);
        tbl[16] = mk(1,9,0,0,0,0,0,0, 0,0,5,0,2,1,0,0);
        tbl[17] = mk(0,0,1,7,2,3,3,0, 0,0,5,0,2,1,0,1);
        tbl[18] = mk(1,6,0,0,0,0,0,0, 0,0,5,0,2,1,1,0);
        tbl[19] = mk(0,0,0,0,0,0,0,0, 1,7,2,0,3,1,1,1);
        tbl[20] = mk(0,0,0,0,0,0,0,0, 1,0,3,1,3,1,1,0);
        tbl[21] = mk(1,6,0,0,0,0,0,0, 0,0,3,0,3,1,0,0);
        tbl[22] = mk(0,0,1,4,3,2,4,0, 0,0,3,0,3,1,0,0);
        tbl[23] = mk(0,0,0,0,0,0,0,0, 0,0,3,0,3,1,1,0);
        tbl[24] = mk(0,0,0,0,0,0,0,0, 1,4,0,0,4,1,1,0);
        tbl[25] = mk(0,0,0,0,0,0,0,0, 1,5,1,0,4,1,1,0);
        tbl[26] = mk(0,0,0,0,0,0,0,0, 1,0,2,1,4,1,1,0);
        tbl[27] = mk(0,0,0,0,0,0,0,0, 0,0,2,0,4,1,0,0);

        reset_n = 1'b0;
        cfg_val = 0; cfg_bcnt = 0; iss_val = 0; iss_bptr = 0;
        iss_vlen = 0; iss_lat = 0; iss_tag = 0; stall = 0;
        step("rst_held", 0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0,0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 28; i++)
            step($sformatf("vec%0d", i), tbl[i].cv, tbl[i].cb, tbl[i].iv, tbl[i].ib, tbl[i].il,
                 tbl[i].ia, tbl[i].it, tbl[i].st, tbl[i].ev, tbl[i].eb, tbl[i].ew, tbl[i].el,
                 tbl[i].et, tbl[i].er, tbl[i].ey, tbl[i].ee);

        // back-to-back ops at bcnt=4; third op waits for a free slot
        step("bb_cfg",  1,4,0,0,0,0,0,0, 0,0,2,0,4,1,0,0);
        step("bb_op1",  0,0,1,1,2,1,5,1, 0,0,2,0,4,1,0,0);
        step("bb_op2",  0,0,1,2,3,0,6,1, 0,0,2,0,4,1,1,0);
        step("bb_full", 0,0,1,3,1,3,7,1, 0,0,2,0,4,0,1,0);
        step("bb_hold", 0,0,1,3,1,3,7,0, 0,0,2,0,4,0,1,0);
        step("bb_s1",   0,0,1,3,1,3,7,0, 1,1,2,0,5,1,1,0);
        step("bb_s2",   0,0,0,0,0,0,0,0, 1,2,3,1,5,0,1,0);
        step("bb_s3",   0,0,0,0,0,0,0,0, 1,2,2,0,6,1,1,0);
        step("bb_s4",   0,0,0,0,0,0,0,0, 1,3,3,0,6,1,1,0);
        step("bb_s5",   0,0,0,0,0,0,0,0, 1,0,0,1,6,1,1,0);
        step("bb_s6",   0,0,0,0,0,0,0,0, 1,3,2,1,7,1,1,0);
        step("bb_end",  0,0,0,0,0,0,0,0, 0,3,2,0,7,1,0,0);

        // 3-cycle stall mid-op at bcnt=3
        step("st_cfg",  1,3,0,0,0,0,0,0, 0,3,2,0,7,1,0,0);
        step("st_op",   0,0,1,0,6,2,8,0, 0,3,2,0,7,1,0,0);
        step("st_ld",   0,0,0,0,0,0,0,0, 0,3,2,0,7,1,1,0);
        step("st_s1",   0,0,0,0,0,0,0,0, 1,0,2,0,8,1,1,0);
        step("st_s2",   0,0,0,0,0,0,0,0, 1,1,0,0,8,1,1,0);
        step("st_h1",   0,0,0,0,0,0,0,1, 0,2,1,0,8,1,1,0);
        step("st_h2",   0,0,0,0,0,0,0,1, 0,2,1,0,8,1,1,0);
        step("st_h3",   0,0,0,0,0,0,0,1, 0,2,1,0,8,1,1,0);
        step("st_s3",   0,0,0,0,0,0,0,0, 1,2,1,0,8,1,1,0);
        step("st_s4",   0,0,0,0,0,0,0,0, 1,0,2,0,8,1,1,0);
        step("st_s5",   0,0,0,0,0,0,0,0, 1,1,0,0,8,1,1,0);
        step("st_s6",   0,0,0,0,0,0,0,0, 1,2,1,1,8,1,1,0);
        step("st_end",  0,0,0,0,0,0,0,0, 0,2,1,0,8,1,0,0);

        // async reset mid-op with a second op buffered
        step("rs_op",   0,0,1,5,10,1,9,0, 0,2,1,0,8,1,0,0);
        step("rs_ld",   0,0,0,0,0,0,0,0,  0,2,1,0,8,1,1,0);
        step("rs_s1",   0,0,1,6,4,0,10,0, 1,2,0,0,9,1,1,0);
        step("rs_s2",   0,0,0,0,0,0,0,0,  1,0,1,0,9,1,1,0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rs_async", 0,0,0,0,0,1,0,0);
        @(negedge clk);
        reset_n = 1'b1;
        step("rs_post1", 0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0,0);
        step("rs_post2", 0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0,0);

        // reset bcnt is 8, then bcnt=3 start normalise and a zero-length op
        step("z_op8",   0,0,1,7,1,0,12,0, 0,0,0,0,0,1,0,0);
        step("z_ld8",   0,0,0,0,0,0,0,0,  0,0,0,0,0,1,1,0);
        step("z_s8",    0,0,0,0,0,0,0,0,  1,7,7,1,12,1,1,0);
        step("z_cfg3",  1,3,0,0,0,0,0,0,  0,7,7,0,12,1,0,0);
        step("z_op0",   0,0,1,7,0,0,10,0, 0,7,7,0,12,1,0,0);
        step("z_opb",   0,0,1,7,2,1,11,0, 0,7,7,0,12,1,1,0);
        step("z_drop",  0,0,0,0,0,0,0,0,  0,7,7,0,12,1,1,0);
        step("z_s1",    0,0,0,0,0,0,0,0,  1,1,2,0,11,1,1,0);
        step("z_s2",    0,0,0,0,0,0,0,0,  1,2,0,1,11,1,1,0);
        step("z_end",   0,0,0,0,0,0,0,0,  0,2,0,0,11,1,0,0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
